mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_arb_sel.sv | 30 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the SDRAM client arbiter.
// Client 3 is the TFT refresh client and always wins arbitration.
package mem_pkg;

    localparam int AN = 24;
    localparam int DN = 16;

    typedef logic [1:0] cli_id_t;

    localparam cli_id_t ID_C0  = 2'b00;
    localparam cli_id_t ID_C1  = 2'b01;
    localparam cli_id_t ID_C2  = 2'b10;
    localparam cli_id_t ID_TFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10
    } arb_state_e;

    // Modulo-3 step over the round-robin clients 0..2.
    function automatic cli_id_t rr_step(cli_id_t p, cli_id_t n);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, n};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selector: TFT first, then round-robin over 0..2.
module mem_arb_sel (
    input  logic [3:0] cli_request,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] grant
);
    import mem_pkg::*;

    cli_id_t idx;
    logic    found;

    always_comb begin
        valid = |cli_request;
        grant = ID_TFT;
        idx   = ID_C0;
        found = 1'b0;
        if (!cli_request[ID_TFT]) begin
            grant = ID_C0;
            for (int i = 0; i < 3; i++) begin
                idx = rr_step(rr_ptr, 2'(i));
                if (!found && cli_request[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Four-client SDRAM request arbiter with a one-cycle guard gap after each
// accepted request, plus a registered read-return demultiplexer.
module mem_arbiter #(
    parameter int AN = mem_pkg::AN,
    parameter int DN = mem_pkg::DN
) (
    input  logic            clkSYS,
    input  logic            n_reset,
    input  logic [3:0]      cli_request,
    input  logic [4*AN-1:0] cli_addr,
    input  logic [4*DN-1:0] cli_wdata,
    input  logic [3:0]      cli_wr,
    output logic [3:0]      cli_ack,
    output logic            request,
    output logic [AN-1:0]   req_addr,
    output logic [DN-1:0]   req_data,
    output logic [1:0]      req_id,
    output logic            req_wr,
    input  logic            req_ack,
    input  logic [DN-1:0]   mem_data,
    input  logic [1:0]      mem_id,
    input  logic            mem_valid,
    output logic [4*DN-1:0] cli_mem_data,
    output logic [3:0]      cli_mem_valid
);
    import mem_pkg::*;

    arb_state_e    state_q, state_d;
    cli_id_t       rr_q, rr_d;
    logic          request_q, request_d;
    logic [AN-1:0] addr_q, addr_d;
    logic [DN-1:0] data_q, data_d;
    cli_id_t       id_q, id_d;
    logic          wr_q, wr_d;
    logic [3:0]    ack_q, ack_d;
    logic [3:0]    mv_q;
    logic [4*DN-1:0] md_q;

    logic    sel_valid;
    cli_id_t sel_id;

    mem_arb_sel u_sel (
        .cli_request (cli_request),
        .rr_ptr      (rr_q),
        .valid       (sel_valid),
        .grant       (sel_id)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        request_d = request_q;
        addr_d    = addr_q;
        data_d    = data_q;
        id_d      = id_q;
        wr_d      = wr_q;
        ack_d     = 4'b0000;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d   = ST_REQ;
                    request_d = 1'b1;
                    addr_d    = cli_addr[int'(sel_id)*AN +: AN];
                    data_d    = cli_wdata[int'(sel_id)*DN +: DN];
                    wr_d      = cli_wr[sel_id];
                    id_d      = sel_id;
                    if (sel_id != ID_TFT) rr_d = rr_step(sel_id, 2'd1);
                end
            end
            ST_REQ: begin
                if (req_ack) begin
                    state_d   = ST_GAP;
                    request_d = 1'b0;
                    ack_d     = 4'b0001 << id_q;
                end
            end
            // A second cycle of req_ack lands here and is ignored.
            ST_GAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            rr_q      <= ID_C0;
            request_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            id_q      <= ID_C0;
            wr_q      <= 1'b0;
            ack_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            request_q <= request_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            id_q      <= id_d;
            wr_q      <= wr_d;
            ack_q     <= ack_d;
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            mv_q <= 4'b0000;
            md_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                mv_q[k] <= mem_valid && (mem_id == 2'(k));
                if (mem_valid && (mem_id == 2'(k)))
                    md_q[k*DN +: DN] <= mem_data;
            end
        end
    end

    assign cli_ack       = ack_q;
    assign request       = request_q;
    assign req_addr      = addr_q;
    assign req_data      = data_q;
    assign req_id        = id_q;
    assign req_wr        = wr_q;
    assign cli_mem_valid = mv_q;
    assign cli_mem_data  = md_q;

endmodule
